// File: rtl/filter_output_quantizer_if.sv
// Sample-stream bundle between the filter, the quantizer and the consumer.
// The master drives samples and ready; the slave returns FIFO head and status.
interface filter_output_quantizer_if #(
  parameter int NBinput    = 64,
  parameter int NBoutput   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int NBcnt      = 16
);
  logic                          in_valid;
  logic [NBinput-1:0]            Y_in;
  logic                          out_ready;
  logic                          out_valid;
  logic [NBoutput-1:0]           out_data;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic [NBcnt-1:0]              sat_cnt;
  logic [NBcnt-1:0]              drop_cnt;

  modport master (
    output in_valid, Y_in, out_ready,
    input  out_valid, out_data, fifo_level, sat_cnt, drop_cnt
  );

  modport slave (
    input  in_valid, Y_in, out_ready,
    output out_valid, out_data, fifo_level, sat_cnt, drop_cnt
  );
endinterface

// File: rtl/filter_output_quantizer.sv
// Rescale (arithmetic shift), saturate and buffer filter samples in a small FIFO.
// Define QUANT_ROUND_EN for round-half-up; otherwise plain truncation.
module filter_output_quantizer #(
  parameter int NBinput    = 64,
  parameter int NBoutput   = 32,
  parameter int SHIFT      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int NBcnt      = 16
) (
  input logic                    clk,
  input logic                    rst,
  filter_output_quantizer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HI = NBinput - NBoutput + 2;
  localparam logic [NBoutput-1:0] MAXV = {1'b0, {(NBoutput-1){1'b1}}};
  localparam logic [NBoutput-1:0] MINV = {1'b1, {(NBoutput-1){1'b0}}};
  localparam logic [NBcnt-1:0]    CMAX = '1;
  localparam logic [LW-1:0]       FULL = LW'(FIFO_DEPTH);

  // ---------------- stage 1: round, shift, clamp ----------------
  logic signed [NBinput:0] t, q;
  logic                    sat_hi, sat_lo;
  logic [NBoutput-1:0]     clamp;

`ifdef QUANT_ROUND_EN
  localparam int SHM1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [NBinput:0] RND =
    (SHIFT > 0) ? ({{NBinput{1'b0}}, 1'b1} << SHM1) : '0;
`endif

  always_comb begin
    t = {bus.Y_in[NBinput-1], bus.Y_in};
`ifdef QUANT_ROUND_EN
    // one guard bit keeps the rounding add from wrapping at the positive limit
    t = t + RND;
`endif
    q      = t >>> SHIFT;
    sat_hi = !q[NBinput] && (|q[NBinput-1:NBoutput-1]);
    sat_lo =  q[NBinput] && !(&q[NBinput-1:NBoutput-1]);
    if (sat_hi)      clamp = MAXV;
    else if (sat_lo) clamp = MINV;
    else             clamp = q[NBoutput-1:0];
  end

  logic                s1_valid_q, s1_valid_d;
  logic                s1_sat_q, s1_sat_d;
  logic [NBoutput-1:0] s1_data_q, s1_data_d;

  always_comb begin
    s1_valid_d = bus.in_valid;
    s1_sat_d   = bus.in_valid && (sat_hi || sat_lo);
    s1_data_d  = bus.in_valid ? clamp : s1_data_q;
  end

  // ---------------- stage 2: FIFO and status ----------------
  logic [NBoutput-1:0] mem_q [FIFO_DEPTH];
  logic [NBoutput-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [NBoutput-1:0] last_q, last_d;
  logic [NBcnt-1:0]    sat_cnt_q, sat_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                full, pop, do_push, drop;

  assign full    = (level_q == FULL);
  assign pop     = (level_q != '0) && bus.out_ready;
  assign do_push = s1_valid_q && (!full || pop);
  assign drop    = s1_valid_q && full && !pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_d     = last_q;
    sat_cnt_d  = sat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = s1_data_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      // remember the departing head so out_data holds it once empty
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (s1_valid_q && s1_sat_q && sat_cnt_q != CMAX) sat_cnt_d = sat_cnt_q + 1'b1;
    if (drop && drop_cnt_q != CMAX) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sat_q   <= 1'b0;
      s1_data_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_q     <= '0;
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sat_q   <= s1_sat_d;
      s1_data_q  <= s1_data_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      last_q     <= last_d;
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.out_valid  = (level_q != '0);
  assign bus.out_data   = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign bus.fifo_level = level_q;
  assign bus.sat_cnt    = sat_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_filter_output_quantizer.sv
// Directed bench for filter_output_quantizer: vector table for quantization,
// hand sequences for FIFO full/drop, pop-with-push and mid-stream reset.
module tb_filter_output_quantizer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  filter_output_quantizer_if #(.NBinput(64), .NBoutput(32), .FIFO_DEPTH(4), .NBcnt(16)) bus ();

  filter_output_quantizer #(
    .NBinput(64), .NBoutput(32), .SHIFT(16), .FIFO_DEPTH(4), .NBcnt(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef QUANT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [63:0] y;
    logic [31:0] e_rnd;
    bit          s_rnd;
    logic [31:0] e_trn;
    bit          s_trn;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int sat_exp = 0;
  int drop_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string name, input int lvl);
    chk({name, " level"}, 64'(bus.fifo_level), 64'(lvl));
    chk({name, " sat_cnt"}, 64'(bus.sat_cnt), 64'(sat_exp));
    chk({name, " drop_cnt"}, 64'(bus.drop_cnt), 64'(drop_exp));
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{64'h0000_0000_0001_8000, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b0};
    vt[1] = '{64'hFFFF_FFFF_FFFE_8000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0};
    vt[2] = '{64'h0000_8000_0000_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vt[3] = '{64'h8000_0000_0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1};
    vt[4] = '{64'h0000_0000_0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vt[5] = '{64'h0000_7FFF_FFFF_7FFF, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0};
    vt[6] = '{64'h0000_7FFF_FFFF_8000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0};
    vt[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vt[8] = '{64'hFFFF_8000_0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0};
    vt[9] = '{64'hFFFF_7FFF_FFFF_FFFF, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.Y_in = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out_data", 64'(bus.out_data), 64'd0);
    chk_status("reset", 0);

    // single-sample quantization, one vector at a time with out_ready=1
    for (int i = 0; i < 10; i++) begin
      logic [31:0] e;
      bit s;
      e = RND ? vt[i].e_rnd : vt[i].e_trn;
      s = RND ? vt[i].s_rnd : vt[i].s_trn;
      bus.in_valid = 1'b1;
      bus.Y_in = vt[i].y;
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d valid after 1 edge", i), 64'(bus.out_valid), 64'd0);
      step();
      if (s) sat_exp++;
      chk($sformatf("v%0d valid after 2 edges", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d data", i), 64'(bus.out_data), 64'(e));
      chk($sformatf("v%0d sat_cnt", i), 64'(bus.sat_cnt), 64'(sat_exp));
      step();
      chk($sformatf("v%0d valid after pop", i), 64'(bus.out_valid), 64'd0);
      chk($sformatf("v%0d data held", i), 64'(bus.out_data), 64'(e));
    end

    // full FIFO: six samples with no consumer, two get dropped
    bus.out_ready = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      bus.in_valid = 1'b1;
      bus.Y_in = 64'(n) << 16;
      step();
    end
    bus.in_valid = 1'b0;
    step();
    drop_exp = 2;
    chk_status("full", 4);
    bus.out_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("drain valid %0d", n), 64'(bus.out_valid), 64'd1);
      chk($sformatf("drain data %0d", n), 64'(bus.out_data), 64'(n));
      step();
    end
    chk("drained valid", 64'(bus.out_valid), 64'd0);
    chk("drained data held", 64'(bus.out_data), 64'd4);
    chk_status("drained", 0);

    // full with simultaneous pop and push: no drop, head advances
    bus.out_ready = 1'b0;
    for (int n = 10; n <= 14; n++) begin
      bus.in_valid = 1'b1;
      bus.Y_in = 64'(n) << 16;
      step();
    end
    bus.in_valid = 1'b0;
    chk_status("refill", 4);
    chk("refill head", 64'(bus.out_data), 64'd10);
    bus.out_ready = 1'b1;
    step();
    chk_status("pop+push at full", 4);
    chk("pop+push head", 64'(bus.out_data), 64'd11);
    step();
    bus.out_ready = 1'b0;
    chk_status("level three", 3);
    chk("level three head", 64'(bus.out_data), 64'd12);

    // mid-stream reset; the sample offered during reset must be ignored
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.Y_in = 64'(99) << 16;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    sat_exp = 0;
    drop_exp = 0;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_data", 64'(bus.out_data), 64'd0);
    chk_status("rst", 0);
    step();
    chk("rst ignored in_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b1;
    bus.Y_in = 64'(7) << 16;
    step();
    bus.in_valid = 1'b0;
    chk("post-rst valid 1 edge", 64'(bus.out_valid), 64'd0);
    step();
    chk("post-rst valid 2 edges", 64'(bus.out_valid), 64'd1);
    chk("post-rst data", 64'(bus.out_data), 64'd7);
    chk_status("post-rst", 1);
    step();
    chk("post-rst popped", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
